nibble_cpu_core: RTL and testbench

//  Parametrised accumulator CPU with a nibble-serial memory bus; next generation of our 4-bit TinyTapeout CPU.

---
 rtl/nibble_cpu_pkg.sv | 34 +++
 rtl/nibble_cpu_alu.sv | 35 +++
 rtl/nibble_cpu_core.sv | 157 +++++++++++++++
 tb/tb_nibble_cpu_core.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_cpu_pkg.sv
// Shared opcode values, FSM state encoding and small elaboration helpers
// for the nibble-serial accumulator CPU.
package nibble_cpu_pkg;

   localparam logic [3:0] OP_NGA = 4'h0;
   localparam logic [3:0] OP_AND = 4'h1;
   localparam logic [3:0] OP_OR  = 4'h2;
   localparam logic [3:0] OP_XOR = 4'h3;
   localparam logic [3:0] OP_SLL = 4'h4;
   localparam logic [3:0] OP_SRL = 4'h5;
   localparam logic [3:0] OP_SRA = 4'h6;
   localparam logic [3:0] OP_ADD = 4'h7;
   localparam logic [3:0] OP_HLT = 4'h8;
   localparam logic [3:0] OP_BEQ = 4'h9;
   localparam logic [3:0] OP_BLE = 4'hA;
   localparam logic [3:0] OP_JMP = 4'hB;
   localparam logic [3:0] OP_LDA = 4'hC;
   localparam logic [3:0] OP_LDB = 4'hD;
   localparam logic [3:0] OP_STA = 4'hE;
   localparam logic [3:0] OP_STB = 4'hF;

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_ADDR  = 3'd1,
      S_LOAD  = 3'd2,
      S_STORE = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/nibble_cpu_alu.sv
// Combinational ALU for the single-beat ops 0-7; result always lands in A.
module nibble_cpu_alu
   import nibble_cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result
);

   localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   // For non-power-of-two widths the amount field can exceed DATA_W-1;
   // the native shift operators then yield zero or sign fill as intended.
   logic [SH_W-1:0] shamt;
   assign shamt = b[SH_W-1:0];

   always_comb begin
      result = '0;
      case (op)
         OP_NGA[2:0]: result = -a;
         OP_AND[2:0]: result = a & b;
         OP_OR[2:0]:  result = a | b;
         OP_XOR[2:0]: result = a ^ b;
         OP_SLL[2:0]: result = a << shamt;
         OP_SRL[2:0]: result = a >> shamt;
         OP_SRA[2:0]: result = $unsigned($signed(a) >>> shamt);
         OP_ADD[2:0]: result = a + b;
         default:     result = '0;
      endcase
   end

endmodule

// File: rtl/nibble_cpu_core.sv
// Accumulator CPU with a nibble-serial bus: opcode, MS-first address operand,
// then MS-first data beats; bus_rdy = 0 freezes every register.
module nibble_cpu_core
   import nibble_cpu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int BUS_W  = 4
) (
   input  logic              clk,
   input  logic              rst_p,
   input  logic [BUS_W-1:0]  bus_in,
   input  logic              bus_rdy,
   output logic [ADDR_W-1:0] addr_out,
   output logic [BUS_W-1:0]  data_out,
   output logic              wcyc,
   output logic              halted
);

   localparam int AN     = ADDR_W / BUS_W;
   localparam int DN     = DATA_W / BUS_W;
   localparam int NMAX   = max_int(AN, DN);
   localparam int BEAT_W = (NMAX > 1) ? $clog2(NMAX) : 1;
   localparam logic [BEAT_W-1:0] AN_LAST = BEAT_W'(AN - 1);
   localparam logic [BEAT_W-1:0] DN_LAST = BEAT_W'(DN - 1);

   generate
      if ((DATA_W % BUS_W) != 0 || (ADDR_W % BUS_W) != 0 || BUS_W < 4) begin : g_bad_params
         $error("nibble_cpu_core: DATA_W and ADDR_W must be multiples of BUS_W, and BUS_W >= 4");
      end
   endgenerate

   state_t              state;
   logic [ADDR_W-1:0]   pc;
   logic [ADDR_W-1:0]   op_pc;
   logic [ADDR_W-1:0]   tmp;
   logic [DATA_W-1:0]   reg_a;
   logic [DATA_W-1:0]   reg_b;
   logic [3:0]          op;
   logic [BEAT_W-1:0]   beat;

   logic [DATA_W-1:0]   alu_result;
   logic [ADDR_W-1:0]   addr_word;
   logic [ADDR_W-1:0]   branch_target;
   logic [DATA_W-1:0]   store_src;
   logic [DATA_W-1:0]   store_shifted;

   nibble_cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (bus_in[2:0]),
      .a      (reg_a),
      .b      (reg_b),
      .result (alu_result)
   );

   // Full operand as it stands once the current (last) nibble is appended.
   assign addr_word     = ADDR_W'({tmp, bus_in});
   assign branch_target = op_pc + addr_word;

   always_comb begin
      store_src     = (op == OP_STB) ? reg_b : reg_a;
      store_shifted = store_src >> (BUS_W * (DN - 1 - int'(beat)));
   end

   // Bus outputs decode only registered state, so a stall leaves them untouched.
   always_comb begin
      addr_out = pc;
      data_out = '0;
      wcyc     = 1'b0;
      halted   = 1'b0;
      case (state)
         S_LOAD:  addr_out = tmp + ADDR_W'(beat);
         S_STORE: begin
            addr_out = tmp + ADDR_W'(beat);
            wcyc     = 1'b1;
            data_out = store_shifted[BUS_W-1:0];
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         state <= S_FETCH;
         pc    <= '0;
         op_pc <= '0;
         tmp   <= '0;
         reg_a <= '0;
         reg_b <= '0;
         op    <= '0;
         beat  <= '0;
      end else if (bus_rdy) begin
         case (state)
            S_FETCH: begin
               op    <= bus_in[3:0];
               op_pc <= pc;
               pc    <= pc + ADDR_W'(1);
               if (!bus_in[3]) begin
                  reg_a <= alu_result;
               end else if (bus_in[3:0] == OP_HLT) begin
                  state <= S_HALT;
               end else begin
                  state <= S_ADDR;
                  beat  <= '0;
               end
            end
            S_ADDR: begin
               tmp <= addr_word;
               pc  <= pc + ADDR_W'(1);
               if (beat == AN_LAST) begin
                  beat <= '0;
                  case (op)
                     OP_BEQ: begin
                        if (reg_a == reg_b) pc <= branch_target;
                        state <= S_FETCH;
                     end
                     OP_BLE: begin
                        if (reg_a <= reg_b) pc <= branch_target;
                        state <= S_FETCH;
                     end
                     OP_JMP: begin
                        pc    <= addr_word;
                        state <= S_FETCH;
                     end
                     OP_LDA, OP_LDB: state <= S_LOAD;
                     OP_STA, OP_STB: state <= S_STORE;
                     default:        state <= S_FETCH;
                  endcase
               end else begin
                  beat <= beat + BEAT_W'(1);
               end
            end
            S_LOAD: begin
               if (op == OP_LDB) reg_b <= DATA_W'({reg_b, bus_in});
               else              reg_a <= DATA_W'({reg_a, bus_in});
               if (beat == DN_LAST) begin
                  beat  <= '0;
                  state <= S_FETCH;
               end else begin
                  beat <= beat + BEAT_W'(1);
               end
            end
            S_STORE: begin
               if (beat == DN_LAST) begin
                  beat  <= '0;
                  state <= S_FETCH;
               end else begin
                  beat <= beat + BEAT_W'(1);
               end
            end
            S_HALT:  ;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_cpu_core.sv
// Directed bench: small programs in a nibble memory model, checked against
// hand-computed address traces, store beats and memory contents.
module tb_nibble_cpu_core;

   logic       clk = 1'b0;
   logic       rst_p = 1'b1;
   logic       bus_rdy = 1'b1;
   logic [3:0] bus_in;
   logic [7:0] addr_out;
   logic [3:0] data_out;
   logic       wcyc;
   logic       halted;

   logic [3:0] mem [256];

   logic [7:0] addr_log [64];
   logic       wcyc_log [64];
   logic [3:0] data_log [64];
   logic       halt_log [64];

   int n_vec = 0;
   int n_err = 0;

   nibble_cpu_core #(.DATA_W(8), .ADDR_W(8), .BUS_W(4)) dut (
      .clk      (clk),
      .rst_p    (rst_p),
      .bus_in   (bus_in),
      .bus_rdy  (bus_rdy),
      .addr_out (addr_out),
      .data_out (data_out),
      .wcyc     (wcyc),
      .halted   (halted)
   );

   always #5 clk = ~clk;

   assign bus_in = mem[addr_out];

   always @(posedge clk) begin
      if (wcyc && bus_rdy) mem[addr_out] = data_out;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Unused locations read as HLT so a stray fetch stops the core.
   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 4'h8;
   endtask

   // Reset, then log outputs for n cycles; bit i of stall drops bus_rdy in cycle i.
   task automatic run_trace(input int n, input logic [63:0] stall);
      rst_p   = 1'b1;
      bus_rdy = 1'b1;
      @(negedge clk);
      rst_p = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus_rdy = ~stall[i];
         #1;
         addr_log[i] = addr_out;
         wcyc_log[i] = wcyc;
         data_log[i] = data_out;
         halt_log[i] = halted;
         @(negedge clk);
      end
      bus_rdy = 1'b1;
   endtask

   task automatic run_until_halt(input string tag, input int budget);
      for (int i = 0; i < budget && !halted; i++) @(negedge clk);
      check_eq({tag, "_halt"}, halted, 1'b1);
   endtask

   task automatic load_ldst_prog();
      clear_mem();
      mem[8'h00] = 4'hC; mem[8'h01] = 4'h4; mem[8'h02] = 4'h0;
      mem[8'h03] = 4'hE; mem[8'h04] = 4'h8; mem[8'h05] = 4'h0;
      mem[8'h40] = 4'h9; mem[8'h41] = 4'h6;
   endtask

   task automatic alu_case(input string tag, input logic [3:0] opc,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
      clear_mem();
      mem[8'h00] = 4'hC; mem[8'h01] = 4'h4; mem[8'h02] = 4'h0;
      mem[8'h03] = 4'hD; mem[8'h04] = 4'h4; mem[8'h05] = 4'h2;
      mem[8'h06] = opc;
      mem[8'h07] = 4'hE; mem[8'h08] = 4'h9; mem[8'h09] = 4'h0;
      mem[8'h40] = a[7:4]; mem[8'h41] = a[3:0];
      mem[8'h42] = b[7:4]; mem[8'h43] = b[3:0];
      run_trace(1, 64'h0);
      run_until_halt(tag, 100);
      check_eq(tag, {mem[8'h90], mem[8'h91]}, exp);
   endtask

   logic [7:0] seq_plain [12];
   logic [7:0] seq_stall [17];
   int         moved;

   initial begin
      seq_plain = '{8'h00, 8'h01, 8'h02, 8'h40, 8'h41, 8'h03,
                    8'h04, 8'h05, 8'h80, 8'h81, 8'h06, 8'h07};
      seq_stall = '{8'h00, 8'h01, 8'h02, 8'h40, 8'h41, 8'h41, 8'h41, 8'h41, 8'h03,
                    8'h04, 8'h05, 8'h80, 8'h80, 8'h80, 8'h81, 8'h06, 8'h07};
      clear_mem();

      // Reset values
      #1;
      check_eq("rst_addr", addr_out, 8'h00);
      check_eq("rst_wcyc", wcyc, 1'b0);
      check_eq("rst_data", data_out, 4'h0);
      check_eq("rst_halted", halted, 1'b0);

      // LDA 0x40 then STA 0x80 then HLT
      load_ldst_prog();
      run_trace(12, 64'h0);
      for (int i = 0; i < 12; i++)
         check_eq($sformatf("ldst_addr%0d", i), addr_log[i], seq_plain[i]);
      check_eq("st_wcyc_pre", wcyc_log[7], 1'b0);
      check_eq("st_data_pre", data_log[7], 4'h0);
      check_eq("st_wcyc0", wcyc_log[8], 1'b1);
      check_eq("st_data0", data_log[8], 4'h9);
      check_eq("st_wcyc1", wcyc_log[9], 1'b1);
      check_eq("st_data1", data_log[9], 4'h6);
      check_eq("st_wcyc_post", wcyc_log[10], 1'b0);
      check_eq("st_data_post", data_log[10], 4'h0);
      check_eq("ldst_halted", halt_log[11], 1'b1);
      check_eq("st_mem", {mem[8'h80], mem[8'h81]}, 8'h96);

      // ALU ops
      alu_case("alu_add", 4'h7, 8'hF0, 8'h20, 8'h10);
      alu_case("alu_sra", 4'h6, 8'h90, 8'h01, 8'hC8);
      alu_case("alu_sll", 4'h4, 8'h90, 8'h09, 8'h20);
      alu_case("alu_srl", 4'h5, 8'h90, 8'h03, 8'h12);
      alu_case("alu_sra7", 4'h6, 8'h80, 8'h07, 8'hFF);
      alu_case("alu_nga", 4'h0, 8'h01, 8'h00, 8'hFF);
      alu_case("alu_and", 4'h1, 8'h3C, 8'h0F, 8'h0C);
      alu_case("alu_or", 4'h2, 8'h30, 8'h05, 8'h35);
      alu_case("alu_xor", 4'h3, 8'hFF, 8'h0F, 8'hF0);

      // BEQ taken: JMP 0x10, BEQ +5 with A == B == 0
      clear_mem();
      mem[8'h00] = 4'hB; mem[8'h01] = 4'h1; mem[8'h02] = 4'h0;
      mem[8'h10] = 4'h9; mem[8'h11] = 4'h0; mem[8'h12] = 4'h5;
      run_trace(8, 64'h0);
      check_eq("beq_t_fetch", addr_log[6], 8'h15);
      check_eq("beq_t_halt_addr", addr_log[7], 8'h16);
      check_eq("beq_t_halted", halt_log[7], 1'b1);

      // BEQ not taken: A = 0x12, B = 0
      clear_mem();
      mem[8'h00] = 4'hC; mem[8'h01] = 4'h4; mem[8'h02] = 4'h0;
      mem[8'h03] = 4'hB; mem[8'h04] = 4'h1; mem[8'h05] = 4'h0;
      mem[8'h10] = 4'h9; mem[8'h11] = 4'h0; mem[8'h12] = 4'h5;
      mem[8'h40] = 4'h1; mem[8'h41] = 4'h2;
      run_trace(13, 64'h0);
      check_eq("beq_n_fetch", addr_log[11], 8'h13);
      check_eq("beq_n_halt_addr", addr_log[12], 8'h14);

      // BLE at 0xFE, offset 0x04 straddling the wrap, lands at 0x02 (STB 0xE0)
      clear_mem();
      mem[8'h00] = 4'h4; mem[8'h01] = 4'hB; mem[8'h02] = 4'hF;
      mem[8'h03] = 4'hE; mem[8'h04] = 4'h0;
      mem[8'hFE] = 4'hA; mem[8'hFF] = 4'h0;
      run_trace(14, 64'h0);
      check_eq("ble_fetch_fe", addr_log[4], 8'hFE);
      check_eq("ble_wrap_fetch", addr_log[7], 8'h02);
      check_eq("ble_stb_addr", addr_log[10], 8'hE0);
      check_eq("ble_stb_wcyc", wcyc_log[10], 1'b1);
      check_eq("ble_halt_addr", addr_log[13], 8'h06);
      check_eq("ble_stb_mem", {mem[8'hE0], mem[8'hE1]}, 8'h00);

      // Stall: 3 cycles on the second load beat, 2 cycles on the first store beat
      load_ldst_prog();
      run_trace(17, 64'h0000_0000_0000_1870);
      for (int i = 0; i < 17; i++)
         check_eq($sformatf("stall_addr%0d", i), addr_log[i], seq_stall[i]);
      check_eq("stall_st_wcyc", wcyc_log[12], 1'b1);
      check_eq("stall_st_data", data_log[12], 4'h9);
      check_eq("stall_st_data1", data_log[14], 4'h6);
      check_eq("stall_mem", {mem[8'h80], mem[8'h81]}, 8'h96);

      // HLT freezes the core
      clear_mem();
      run_trace(2, 64'h0);
      check_eq("hlt_addr", addr_log[1], 8'h01);
      check_eq("hlt_halted", halt_log[1], 1'b1);
      moved = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (addr_out !== 8'h01 || halted !== 1'b1 || wcyc !== 1'b0) moved++;
      end
      check_eq("hlt_frozen", moved, 0);

      // Async reset during the second store beat
      load_ldst_prog();
      run_trace(9, 64'h0);
      #1;
      check_eq("mid_st_wcyc", wcyc, 1'b1);
      check_eq("mid_st_addr", addr_out, 8'h81);
      #1;
      rst_p = 1'b1;
      #1;
      check_eq("arst_wcyc", wcyc, 1'b0);
      check_eq("arst_addr", addr_out, 8'h00);
      check_eq("arst_data", data_out, 4'h0);
      @(negedge clk);
      rst_p = 1'b0;
      #1;
      check_eq("restart_addr0", addr_out, 8'h00);
      @(negedge clk);
      #1;
      check_eq("restart_addr1", addr_out, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
